// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one registered 8-bit ALU among NREQ requesters.
// Define ALU_ARB_CARRY_CHAIN_EN to keep a per-requester carry/borrow for CADD/BSUB chains.
module alu_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [5*NREQ-1:0] req_opcode,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_result,
    output logic [4:0]        rsp_flags,
    output logic              rsp_err,
    output logic [4:0]        alu_opcode,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic              alu_enable,
    output logic              alu_input_ready,
    output logic              alu_carry_in,
    output logic              alu_borrow_in,
    input  logic [7:0]        alu_result,
    input  logic              alu_carry_out,
    input  logic              alu_borrow_out,
    input  logic              alu_zero,
    input  logic              alu_negative,
    input  logic              alu_overflow
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
    state_t         state;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] gid;
    logic [IDW-1:0] pick;
    logic [4:0]     op_q;
    logic [7:0]     a_q;
    logic [7:0]     b_q;
    logic           err_q;
    logic           pend;

    // Scan downward so the nearest requester after last_grant overwrites the rest.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] last);
        logic [IDW-1:0] p;
        p = last;
        for (int k = NREQ; k >= 1; k--)
            if (v[(int'(last) + k) % NREQ]) p = IDW'((int'(last) + k) % NREQ);
        return p;
    endfunction

    assign pick            = rr_pick(req_valid, last_grant);
    assign alu_input_ready = alu_enable;

    // The ALU output of the op enabled during CAPTURE lands one cycle later; pend marks that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            gid        <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            err_q      <= 1'b0;
            pend       <= 1'b0;
            req_ready  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            alu_enable <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            req_ready  <= '0;
            alu_enable <= 1'b0;
            rsp_valid  <= pend;
            pend       <= 1'b0;
            if (pend) begin
                rsp_id     <= gid;
                rsp_result <= err_q ? 8'd0 : alu_result;
                rsp_flags  <= err_q ? 5'd0 : {alu_overflow, alu_negative, alu_zero, alu_borrow_out, alu_carry_out};
                rsp_err    <= err_q;
            end
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state      <= ISSUE;
                        req_ready  <= NREQ'(1) << pick;
                        last_grant <= pick;
                        gid        <= pick;
                        op_q       <= req_opcode[5*pick +: 5];
                        a_q        <= req_a[8*pick +: 8];
                        b_q        <= req_b[8*pick +: 8];
                        err_q      <= req_opcode[5*pick +: 5] > 5'd19;
                    end
                end
                ISSUE: begin
                    state      <= CAPTURE;
                    alu_enable <= !err_q;
                    alu_opcode <= op_q;
                    alu_a      <= a_q;
                    alu_b      <= b_q;
                end
                CAPTURE: begin
                    state <= IDLE;
                    pend  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_CARRY_CHAIN_EN
    logic [NREQ-1:0] cflag;
    logic [NREQ-1:0] bflag;

    always_ff @(posedge clk) begin
        if (rst) begin
            cflag         <= '0;
            bflag         <= '0;
            alu_carry_in  <= 1'b0;
            alu_borrow_in <= 1'b0;
        end else begin
            alu_carry_in  <= (state == ISSUE) && cflag[gid];
            alu_borrow_in <= (state == ISSUE) && bflag[gid];
            if (pend && !err_q) begin
                cflag[gid] <= alu_carry_out;
                bflag[gid] <= alu_borrow_out;
            end
        end
    end
`else
    assign alu_carry_in  = 1'b0;
    assign alu_borrow_in = 1'b0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table and sequences for alu_arbiter against a small registered ALU model.
module tb_alu_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req_valid = '0;
    logic [3:0]      req_ready;
    logic [19:0]     req_opcode = '0;
    logic [31:0]     req_a = '0;
    logic [31:0]     req_b = '0;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [7:0]      rsp_result;
    logic [4:0]      rsp_flags;
    logic            rsp_err;
    logic [4:0]      alu_opcode;
    logic [7:0]      alu_a;
    logic [7:0]      alu_b;
    logic            alu_enable;
    logic            alu_input_ready;
    logic            alu_carry_in;
    logic            alu_borrow_in;
    logic [7:0]      m_res;
    logic            m_c;
    logic            m_b;
    logic            m_v;
    logic            m_z;
    logic            m_n;
    logic [8:0]      sum;
    logic [8:0]      dif;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_enable(alu_enable), .alu_input_ready(alu_input_ready),
        .alu_carry_in(alu_carry_in), .alu_borrow_in(alu_borrow_in),
        .alu_result(m_res), .alu_carry_out(m_c), .alu_borrow_out(m_b),
        .alu_zero(m_z), .alu_negative(m_n), .alu_overflow(m_v)
    );

    always #5 clk = ~clk;

    // ALU model: 0 ADD, 1 CADD, 2 SUB, 3 BSUB, anything else XOR; outputs registered on enable.
    assign sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, (alu_opcode == 5'd1) && alu_carry_in};
    assign dif = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, (alu_opcode == 5'd3) && alu_borrow_in};
    assign m_z = (m_res == 8'd0);
    assign m_n = m_res[7];

    always @(posedge clk) begin
        if (rst) begin
            m_res <= '0;
            m_c   <= 1'b0;
            m_b   <= 1'b0;
            m_v   <= 1'b0;
        end else if (alu_enable) begin
            if (alu_opcode <= 5'd1) begin
                m_res <= sum[7:0];
                m_c   <= sum[8];
                m_b   <= 1'b0;
                m_v   <= (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
            end else if (alu_opcode <= 5'd3) begin
                m_res <= dif[7:0];
                m_c   <= 1'b0;
                m_b   <= dif[8];
                m_v   <= (alu_a[7] != alu_b[7]) && (dif[7] != alu_a[7]);
            end else begin
                m_res <= alu_a ^ alu_b;
                m_c   <= 1'b0;
                m_b   <= 1'b0;
                m_v   <= 1'b0;
            end
        end
    end

    int total = 0;
    int bad = 0;
    int r_rdy, r_rsp, r_en, r_en_at, r_id, r_res, r_flags, r_err, r_rvec, r_ir_bad;

    typedef struct {
        int id;
        int op;
        int a;
        int b;
        int res;
        int flags;
        int err;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Raise requester id (plus any extra requesters), drop all on the first grant, wait for the response.
    task automatic run_op(input int id, input int op, input int a, input int b, input logic [3:0] extra);
        req_opcode[5*id +: 5] = 5'(op);
        req_a[8*id +: 8] = 8'(a);
        req_b[8*id +: 8] = 8'(b);
        req_valid = extra | (4'b0001 << id);
        r_rdy = -1; r_rsp = -1; r_en = 0; r_en_at = -1; r_rvec = 0; r_ir_bad = 0;
        r_id = -1; r_res = -1; r_flags = -1; r_err = -1;
        for (int k = 1; k <= 20 && r_rsp < 0; k++) begin
            @(negedge clk);
            if (alu_input_ready != alu_enable) r_ir_bad++;
            if (alu_enable) begin
                r_en++;
                r_en_at = k;
            end
            if (req_ready != 0 && r_rdy < 0) begin
                r_rdy = k;
                r_rvec = int'(req_ready);
                req_valid = '0;
            end
            if (rsp_valid) begin
                r_rsp = k;
                r_id = int'(rsp_id);
                r_res = int'(rsp_result);
                r_flags = int'(rsp_flags);
                r_err = int'(rsp_err);
            end
        end
        req_valid = '0;
    endtask

    int g_id[8], rs_id[8], rs_cyc[8], rs_val[8];
    int ng, nr, cnt_v, cnt_e, found;

    initial begin
        vecs[0] = '{0, 0, 5,    3,    8,    5'b00000, 0};
        vecs[1] = '{1, 0, 8'h7F, 1,   8'h80, 5'b11000, 0};
        vecs[2] = '{2, 0, 8'hFF, 1,   0,    5'b00101, 0};
        vecs[3] = '{3, 2, 3,    5,    8'hFE, 5'b01010, 0};
        vecs[4] = '{0, 2, 8'h80, 1,   8'h7F, 5'b10000, 0};
        vecs[5] = '{1, 19, 8'hF0, 8'h0F, 8'hFF, 5'b01000, 0};
        vecs[6] = '{2, 25, 9,   9,    0,    5'b00000, 1};
        vecs[7] = '{3, 20, 4,   4,    0,    5'b00000, 1};
        vecs[8] = '{0, 2, 7,    7,    0,    5'b00100, 0};
        vecs[9] = '{1, 0, 8'h40, 8'h40, 8'h80, 5'b11000, 0};

        repeat (3) @(negedge clk);
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_id", int'(rsp_id), 0);
        chk("reset_rsp_result", int'(rsp_result), 0);
        chk("reset_rsp_flags", int'(rsp_flags), 0);
        chk("reset_rsp_err", int'(rsp_err), 0);
        chk("reset_alu_enable", int'(alu_enable), 0);
        chk("reset_alu_opcode", int'(alu_opcode), 0);
        chk("reset_alu_ab", int'({alu_a, alu_b}), 0);
        chk("reset_alu_cb_in", int'({alu_carry_in, alu_borrow_in}), 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, 4'b0000);
            chk($sformatf("v%0d_ready_vec", i), r_rvec, 1 << vecs[i].id);
            chk($sformatf("v%0d_ready_lat", i), r_rdy, 1);
            chk($sformatf("v%0d_rsp_lat", i), r_rsp - r_rdy, 3);
            chk($sformatf("v%0d_rsp_id", i), r_id, vecs[i].id);
            chk($sformatf("v%0d_result", i), r_res, vecs[i].res);
            chk($sformatf("v%0d_flags", i), r_flags, vecs[i].flags);
            chk($sformatf("v%0d_err", i), r_err, vecs[i].err);
            chk($sformatf("v%0d_enable_count", i), r_en, vecs[i].err ? 0 : 1);
            if (vecs[i].err == 0) chk($sformatf("v%0d_enable_at", i), r_en_at - r_rdy, 1);
            chk($sformatf("v%0d_input_ready_eq_enable", i), r_ir_bad, 0);
        end

        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_opcode[5*i +: 5] = 5'd0;
            req_a[8*i +: 8] = 8'(i);
            req_b[8*i +: 8] = 8'd10;
        end
        req_valid = 4'hF;
        ng = 0;
        nr = 0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (req_ready != 0 && ng < 8) begin
                found = -1;
                for (int j = 0; j < 4; j++) if (req_ready[j]) found = j;
                g_id[ng] = found;
                ng++;
            end
            if (rsp_valid && nr < 8) begin
                rs_id[nr] = int'(rsp_id);
                rs_cyc[nr] = k;
                rs_val[nr] = int'(rsp_result);
                nr++;
            end
        end
        req_valid = '0;
        repeat (4) @(negedge clk);
        chk("rr_grant_count", ng, 6);
        chk("rr_rsp_count", nr, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_grant%0d", i), g_id[i], i % 4);
            chk($sformatf("rr_rsp_id%0d", i), rs_id[i], i % 4);
            chk($sformatf("rr_rsp_val%0d", i), rs_val[i], (i % 4) + 10);
            if (i > 0) chk($sformatf("rr_rsp_gap%0d", i), rs_cyc[i] - rs_cyc[i-1], 3);
        end

        do_reset();
        run_op(1, 0, 200, 100, 4'b0000);
        chk("chain_add_result", r_res, 44);
        chk("chain_add_flags", r_flags, 5'b00001);
        run_op(0, 1, 1, 1, 4'b0000);
        chk("chain_cadd_req0", r_res, 2);
        run_op(1, 1, 1, 1, 4'b0000);
`ifdef ALU_ARB_CARRY_CHAIN_EN
        chk("chain_cadd_req1", r_res, 3);
`else
        chk("chain_cadd_req1", r_res, 2);
`endif

        do_reset();
        req_opcode[10 +: 5] = 5'd0;
        req_a[16 +: 8] = 8'd1;
        req_b[16 +: 8] = 8'd1;
        req_valid = 4'b0100;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clk);
            if (req_ready != 0) found = int'(req_ready);
        end
        chk("rst_issue_ready", found, 4);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        cnt_v = 0;
        cnt_e = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid) cnt_v++;
            if (alu_enable) cnt_e++;
        end
        chk("rst_issue_no_rsp", cnt_v, 0);
        chk("rst_issue_no_enable", cnt_e, 0);
        req_opcode[15 +: 5] = 5'd0;
        req_a[24 +: 8] = 8'd9;
        req_b[24 +: 8] = 8'd9;
        run_op(1, 0, 20, 22, 4'b1000);
        chk("post_rst_ready_vec", r_rvec, 2);
        chk("post_rst_rsp_id", r_id, 1);
        chk("post_rst_result", r_res, 42);
        chk("post_rst_rsp_lat", r_rsp - r_rdy, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
